// File: rtl/ct_pkg.sv
// rtl/ct_pkg.sv - shared routing state encoding and width helper for the crossbar split/merge stages
package ct_pkg;

  typedef enum logic {
    S_HEAD = 1'b0,
    S_BODY = 1'b1
  } state_e;

  // Bits needed to represent value (minimum 1), used to size the destination field.
  function automatic int CLogB2(input int value);
    int bits;
    bits = 1;
    for (int i = 1; i < 32; i++) begin
      if ((value >> i) != 0) bits = i + 1;
    end
    return bits;
  endfunction

endpackage

// File: rtl/ct_skid.sv
// rtl/ct_skid.sv - two-entry skid buffer with registered upstream ready
module ct_skid #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             main_full_q, main_full_d;
  logic             skid_full_q, skid_full_d;
  logic             ready_q, ready_d;
  logic             fire, accept;

  assign fire    = main_full_q && i_ready;
  assign accept  = i_valid && ready_q;
  assign o_data  = main_data_q;
  assign o_valid = main_full_q;
  assign o_ready = ready_q;

  // Next-state for both entries: the skid entry always drains into main first so order is kept.
  always_comb begin
    main_data_d = main_data_q;
    main_full_d = main_full_q;
    skid_data_d = skid_data_q;
    skid_full_d = skid_full_q;
    if (fire || !main_full_q) begin
      if (skid_full_q) begin
        main_data_d = skid_data_q;
        main_full_d = 1'b1;
        skid_full_d = accept;
        if (accept) skid_data_d = i_data;
      end else begin
        main_full_d = accept;
        if (accept) main_data_d = i_data;
      end
    end else if (accept) begin
      skid_full_d = 1'b1;
      skid_data_d = i_data;
    end
    ready_d = !skid_full_d;
  end

  // Entry registers; ready comes up one edge after reset release because it is registered.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_data_q <= '0;
      skid_data_q <= '0;
      main_full_q <= 1'b0;
      skid_full_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
      main_full_q <= main_full_d;
      skid_full_q <= skid_full_d;
      ready_q     <= ready_d;
    end
  end

endmodule

// File: rtl/ct_split.sv
// rtl/ct_split.sv - packet demultiplexer steering whole packets to one of RADIX outputs
module ct_split
  import ct_pkg::*;
#(
  parameter int RADIX    = 2,
  parameter int WIDTH    = 1,
  parameter int EOP_LOC  = 0,
  parameter int DEST_LOC = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_valid,
  output logic               o_ready,
  output logic [RADIX*WIDTH-1:0] o_data,
  output logic [RADIX-1:0]   o_valid,
  input  logic [RADIX-1:0]   i_ready,
  output logic               o_err
);

  localparam int RADBITS = CLogB2(RADIX - 1);

  state_e             state_q;
  logic [RADBITS-1:0] dest_q;
  logic               drop_q;
  logic               err_q;

  logic [RADBITS-1:0] head_dest, cur_dest, sk_dest;
  logic               head_oor, cur_drop, eop, accept;
  logic [WIDTH-1:0]   sk_beat;
  logic               sk_full, sk_ready;

  // Shift rather than part-select so the field extraction stays in range for any legal width.
  assign head_dest = RADBITS'(i_data >> DEST_LOC);
  assign head_oor  = int'(head_dest) >= RADIX;
  assign eop       = i_data[EOP_LOC];
  assign accept    = i_valid && o_ready;
  assign o_err     = err_q;

  // Head beats route on their own field; body beats follow the destination latched at the head.
  always_comb begin
    cur_dest = dest_q;
    cur_drop = drop_q;
    if (state_q == S_HEAD) begin
      cur_dest = head_dest;
      cur_drop = head_oor;
    end
  end

  // Packet routing FSM: latches destination/drop at a multi-beat head, releases at EOP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_HEAD;
      dest_q  <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept && (state_q == S_HEAD) && head_oor;
      if (accept) begin
        case (state_q)
          S_HEAD: begin
            if (!eop) begin
              state_q <= S_BODY;
              dest_q  <= head_dest;
              drop_q  <= head_oor;
            end
          end
          S_BODY: begin
            if (eop) begin
              state_q <= S_HEAD;
              drop_q  <= 1'b0;
            end
          end
          default: state_q <= S_HEAD;
        endcase
      end
    end
  end

  // Dropped beats are still accepted upstream but never enter the buffer.
  ct_skid #(
    .WIDTH(WIDTH + RADBITS)
  ) u_skid (
    .clk    (clk),
    .reset_n(reset_n),
    .i_data ({cur_dest, i_data}),
    .i_valid(i_valid && !cur_drop),
    .o_ready(o_ready),
    .o_data ({sk_dest, sk_beat}),
    .o_valid(sk_full),
    .i_ready(sk_ready)
  );

  // Only the lane matching the head entry's destination can fire; other lanes' ready is ignored.
  assign sk_ready = |(o_valid & i_ready);
  assign o_data   = {RADIX{sk_beat}};

  for (genvar k = 0; k < RADIX; k++) begin : g_lane
    assign o_valid[k] = sk_full && (sk_dest == RADBITS'(k));
  end

endmodule

// File: tb/tb_ct_split.sv
// tb/tb_ct_split.sv - directed self-checking bench for ct_split at RADIX 4 and RADIX 3
module tb_ct_split;

  logic        clk;
  logic        reset_n;

  logic [7:0]  in4_data;
  logic        in4_valid;
  logic        rdy4;
  logic [31:0] data4;
  logic [3:0]  valid4;
  logic [3:0]  ready4;
  logic        err4;

  logic [7:0]  in3_data;
  logic        in3_valid;
  logic        rdy3;
  logic [23:0] data3;
  logic [2:0]  valid3;
  logic [2:0]  ready3;
  logic        err3;

  int n_checks = 0;
  int n_pass   = 0;
  logic err4_seen = 1'b0;

  ct_split #(.RADIX(4), .WIDTH(8), .EOP_LOC(0), .DEST_LOC(1)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .i_data(in4_data), .i_valid(in4_valid),
    .o_ready(rdy4), .o_data(data4), .o_valid(valid4), .i_ready(ready4), .o_err(err4)
  );

  ct_split #(.RADIX(3), .WIDTH(8), .EOP_LOC(0), .DEST_LOC(1)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .i_data(in3_data), .i_valid(in3_valid),
    .o_ready(rdy3), .o_data(data3), .o_valid(valid3), .i_ready(ready3), .o_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (reset_n && err4) err4_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  function automatic logic [7:0] bt(input logic [4:0] pl, input logic [1:0] d, input logic e);
    return {pl, d, e};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] b1[3];
  logic [3:0] v1[3];
  logic [7:0] pk[4];
  logic [7:0] bp[6];
  int         exp_rdy[12] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int         exp_idx[12] = '{-1, 0, 1, 1, 1, 1, 1, 2, 3, 4, 5, -1};
  logic [7:0] rcv[$];
  logic [7:0] q3[3];
  logic [7:0] tmp;

  initial begin
    reset_n   = 1'b0;
    in4_data  = '0; in4_valid = 1'b0; ready4 = 4'hF;
    in3_data  = '0; in3_valid = 1'b0; ready3 = 3'h7;

    // reset
    repeat (3) tick();
    check("rst_valid4", valid4, 0);
    check("rst_ready4", rdy4, 0);
    check("rst_err4", err4, 0);
    check("rst_valid3", valid3, 0);
    check("rst_ready3", rdy3, 0);
    reset_n = 1'b1;
    tick();
    check("rel_ready4", rdy4, 1);
    check("rel_ready3", rdy3, 1);
    check("rel_valid4", valid4, 0);

    // single-beat packets to 2, 0, 3 back to back
    b1[0] = bt(5'd1, 2'd2, 1'b1); v1[0] = 4'b0100;
    b1[1] = bt(5'd2, 2'd0, 1'b1); v1[1] = 4'b0001;
    b1[2] = bt(5'd3, 2'd3, 1'b1); v1[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      in4_data = b1[i]; in4_valid = 1'b1;
      tick();
      check("single_valid", valid4, v1[i]);
      tmp = b1[i];
      check("single_data", data4, {tmp, tmp, tmp, tmp});
    end
    in4_valid = 1'b0;
    tick();
    check("single_idle", valid4, 0);

    // 4-beat packet: head to 1, body fields say 3 and must be ignored
    pk[0] = bt(5'd4, 2'd1, 1'b0);
    pk[1] = bt(5'd5, 2'd3, 1'b0);
    pk[2] = bt(5'd6, 2'd3, 1'b0);
    pk[3] = bt(5'd7, 2'd3, 1'b1);
    for (int i = 0; i < 4; i++) begin
      in4_data = pk[i]; in4_valid = 1'b1;
      tick();
      check("body_valid", valid4, 4'b0010);
      check("body_data", data4[15:8], pk[i]);
    end
    in4_data = bt(5'd8, 2'd2, 1'b1);
    tick();
    check("after_eop_head", valid4, 4'b0100);
    in4_valid = 1'b0;
    tick();
    check("after_eop_idle", valid4, 0);

    // backpressure: 6 beats to 0, lane 0 stalled in cycles 2..5
    for (int i = 0; i < 6; i++) bp[i] = bt(5'(10 + i), 2'd0, (i == 5));
    begin
      int idx;
      logic acc;
      idx = 0;
      for (int c = 0; c < 12; c++) begin
        in4_valid = (idx < 6);
        in4_data  = (idx < 6) ? bp[idx] : 8'h00;
        ready4    = (c >= 2 && c <= 5) ? 4'b1110 : 4'b1111;
        check($sformatf("bp_ready_c%0d", c), rdy4, exp_rdy[c]);
        check($sformatf("bp_valid_c%0d", c), valid4, (exp_idx[c] >= 0) ? 4'b0001 : 4'b0000);
        if (exp_idx[c] >= 0) check($sformatf("bp_data_c%0d", c), data4[7:0], bp[exp_idx[c]]);
        acc = in4_valid && rdy4;
        if (valid4[0] && ready4[0]) rcv.push_back(data4[7:0]);
        tick();
        if (acc) idx++;
      end
    end
    in4_valid = 1'b0;
    check("bp_count", rcv.size(), 6);
    for (int i = 0; i < 6 && i < rcv.size(); i++) check("bp_order", rcv[i], bp[i]);

    // head-of-line: packet to stalled output 1 blocks a later packet to output 0
    ready4 = 4'b1101;
    in4_data = bt(5'd20, 2'd1, 1'b1); in4_valid = 1'b1;
    tick();
    check("hol_first", valid4, 4'b0010);
    in4_data = bt(5'd21, 2'd0, 1'b1);
    tick();
    in4_valid = 1'b0;
    check("hol_block", valid4, 4'b0010);
    check("hol_data1", data4[15:8], bt(5'd20, 2'd1, 1'b1));
    check("hol_ready", rdy4, 0);
    repeat (2) begin
      tick();
      check("hol_hold", valid4, 4'b0010);
    end
    ready4 = 4'b1111;
    tick();
    check("hol_release", valid4, 4'b0001);
    check("hol_data0", data4[7:0], bt(5'd21, 2'd0, 1'b1));
    tick();
    check("hol_idle", valid4, 0);

    // RADIX 3: destination 3 is out of range, whole packet dropped
    q3[0] = bt(5'd1, 2'd3, 1'b0);
    q3[1] = bt(5'd2, 2'd0, 1'b0);
    q3[2] = bt(5'd3, 2'd1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      in3_data = q3[i]; in3_valid = 1'b1;
      tick();
      check("drop_err", err3, (i == 0));
      check("drop_valid", valid3, 0);
      check("drop_ready", rdy3, 1);
    end
    in3_valid = 1'b0;
    tick();
    check("drop_err_idle", err3, 0);
    check("drop_valid_idle", valid3, 0);
    in3_data = bt(5'd9, 2'd2, 1'b1); in3_valid = 1'b1;
    tick();
    in3_valid = 1'b0;
    check("next_valid", valid3, 3'b100);
    check("next_data", data3[23:16], bt(5'd9, 2'd2, 1'b1));
    check("next_err", err3, 0);
    tick();
    check("next_idle", valid3, 0);

    check("err4_never", err4_seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ct_split.md
Name: ct_split

Overview:
- Packet demultiplexer; the stage directly upstream of ct_merge in a crossbar.
- One input stream enters; each packet is steered to one of RADIX outputs. Each output feeds one ct_merge input lane.
- The destination is taken from a field in the first beat and held until EOP, so packets are never interleaved or split across outputs.
- Output side is a 2-entry skid buffer, so the upstream ready is a registered signal.

Parameters:
- RADIX, 2: number of outputs; must be >= 2.
- WIDTH, 1: beat width in bits; must be >= DEST_LOC+RADBITS and > EOP_LOC.
- EOP_LOC, 0: bit index of the end-of-packet flag within a beat.
- DEST_LOC, 1: LSB index of the destination field within a beat; the field is RADBITS wide.
- RADBITS (local), CLogB2(RADIX-1).

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- i_data  in  WIDTH  input beat.
- i_valid  in  1  input beat valid.
- o_ready  out  1  input ready; registered.
- o_data  out  RADIX*WIDTH  output beats; lane k = bits [WIDTH*k +: WIDTH]; all lanes carry the same head-of-buffer beat.
- o_valid  out  RADIX  per-output valid; at most one bit set.
- i_ready  in  RADIX  per-output ready.
- o_err  out  1  one-cycle pulse when the first beat of a packet with out-of-range destination is accepted.

Behaviour:
- Reset (reset_n low, async): o_valid=0, o_ready=0, o_err=0, both skid entries empty, state=S_HEAD, latched dest=0. o_ready rises on the first clk edge after reset_n deasserts.
- Accept: an input beat is accepted when i_valid && o_ready. Fire: a beat is delivered when o_valid[d] && i_ready[d], where d is the head entry's destination.
- Routing FSM, evaluated on each accepted beat:
  - S_HEAD: beat destination = i_data[DEST_LOC +: RADBITS]. If the beat is not EOP, latch the destination and go to S_BODY. If EOP (single-beat packet), stay in S_HEAD.
  - S_BODY: beat destination = latched value; the beat's own field is ignored. On an EOP beat, return to S_HEAD.
- Out-of-range destination (>= RADIX, possible when RADIX is not a power of 2):
  - The whole packet is dropped: all its beats are accepted normally but never written to the buffer, so o_valid is never set.
  - o_err pulses for 1 cycle on the head-beat acceptance.
  - A drop flag is latched with the destination and cleared at EOP.
- Buffer: two entries, main and skid; each holds {data, dest}.
  - An accepted beat goes to main if main is empty or main fires in the same cycle; otherwise it goes to skid.
  - When main fires, skid (if full) moves into main.
  - o_ready next = !(skid full after this edge).
  - o_valid[k] = main full && main.dest == k.
  - Latency: a beat accepted at edge n is visible on o_valid/o_data after edge n, i.e. 1 cycle.
- Throughput: 1 beat/cycle sustained while the selected i_ready is high.
- Simultaneous accept and fire with skid empty: the new beat replaces main; no bubble.
- Stall: a head beat waiting on i_ready[d] blocks all traffic (no bypass to other outputs); i_ready of non-selected lanes is ignored.
- o_data is stable while its o_valid bit is high and unfired.
- Reset mid-packet: the buffer is flushed and the FSM returns to S_HEAD. The next accepted beat is treated as a head.

Decomposition:
- Shared package ct_pkg: CLogB2 function; state encodings S_HEAD=1'b0, S_BODY=1'b1.
- Sub-module ct_skid: 2-entry skid buffer. Parameter WIDTH; ports clk, reset_n, i_data, i_valid, o_ready, o_data, o_valid, i_ready. ct_split instantiates it with width WIDTH+RADBITS.
- Routing FSM, drop logic and lane decode stay in ct_split.

Test Plan:
- Reset release: reset_n low 3 cycles, then high -> o_valid=0 and o_ready=0 during reset; o_ready=1 on the first edge after release; o_err never pulses.
- Single-beat packets, RADIX=4, i_ready=4'hF: destinations 2, 0, 3 with EOP=1 on consecutive cycles -> o_valid = 4'b0100, 4'b0001, 4'b1000 on the next three cycles; each o_data lane equals the input beat.
- 4-beat packet, head destination 1, body beats carrying destination field 3 -> all 4 beats appear on o_valid[1] only; state returns to S_HEAD after the EOP beat.
- Backpressure: stream 6 beats to destination 0 with i_ready[0] low for cycles 2-5 -> o_ready low one cycle after the skid fills; no beat lost or duplicated; order preserved; o_valid[0] held steady while stalled.
- Head-of-line block: packet to output 1 (i_ready[1]=0), then packet to output 0 (i_ready[0]=1) -> o_valid[0] stays 0 until output 1 drains.
- RADIX=3, head destination 3, 3-beat packet -> o_err high exactly 1 cycle; o_valid stays 0; the following packet to destination 2 is delivered normally.
